player_controller: RTL

- Per-player motion and action sequencer feeding player_blob's x_in, y_in, player_direction and player_state.
- Advances once per video frame, on a one-cycle frame_tick pulse.
- Button direction → clamped proposed position → collision query to the map/counter logic → commit or reject.
- Also times chopping and accepts held-item state loads from game logic.

---
 rtl/player_controller_if.sv | 20 ++
 rtl/player_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/player_controller_if.sv
// Position-query handshake between the player controller and the map/counter
// collision logic. The controller proposes a coordinate and holds it until
// the map accepts it, answering in the same cycle whether the tile is blocked.
interface player_controller_if;
    logic        query_valid_out;
    logic [10:0] query_x_out;
    logic [9:0]  query_y_out;
    logic        query_ready_in;
    logic        blocked_in;

    modport master (
        output query_valid_out, query_x_out, query_y_out,
        input  query_ready_in, blocked_in
    );

    modport slave (
        input  query_valid_out, query_x_out, query_y_out,
        output query_ready_in, blocked_in
    );
endinterface

// File: rtl/player_controller.sv
// Per-player motion and action sequencer. Once per frame it either advances
// a chop in progress, starts a chop, or proposes a one-step move that the map
// logic must approve before the committed position changes. Held-item codes
// from game logic can be loaded at any time.
module player_controller #(
    parameter int unsigned START_X     = 64,
    parameter int unsigned START_Y     = 64,
    parameter int unsigned STEP        = 2,
    parameter int unsigned MIN_X       = 0,
    parameter int unsigned MAX_X       = 992,
    parameter int unsigned MIN_Y       = 0,
    parameter int unsigned MAX_Y       = 736,
    parameter int unsigned CHOP_FRAMES = 60
) (
    input  logic                pixel_clk_in,
    input  logic                rst_n_in,
    input  logic                frame_tick_in,
    input  logic                left_in,
    input  logic                right_in,
    input  logic                up_in,
    input  logic                down_in,
    input  logic                chop_in,
    input  logic                load_state_in,
    input  logic [3:0]          new_state_in,
    player_controller_if.master query,
    output logic [10:0]         x_out,
    output logic [9:0]          y_out,
    output logic [1:0]          direction_out,
    output logic [3:0]          state_out,
    output logic                chop_done_out
);

    localparam int CNT_W = (CHOP_FRAMES > 1) ? $clog2(CHOP_FRAMES) : 1;

    localparam logic [10:0] START_X_W = 11'(START_X);
    localparam logic [9:0]  START_Y_W = 10'(START_Y);
    localparam logic [10:0] STEP_X    = 11'(STEP);
    localparam logic [9:0]  STEP_Y    = 10'(STEP);
    localparam logic [10:0] MIN_X_W   = 11'(MIN_X);
    localparam logic [10:0] MAX_X_W   = 11'(MAX_X);
    localparam logic [9:0]  MIN_Y_W   = 10'(MIN_Y);
    localparam logic [9:0]  MAX_Y_W   = 10'(MAX_Y);
    localparam logic [CNT_W-1:0] CHOP_LAST = CNT_W'(CHOP_FRAMES - 1);

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [3:0] ST_NOTHING  = 4'd0;
    localparam logic [3:0] ST_CHOPPING = 4'd1;
    localparam logic [3:0] ST_MAX_CODE = 4'd10;

    typedef enum logic {
        IDLE,
        QUERY
    } fsm_t;

    fsm_t             fsm_q;
    logic [CNT_W-1:0] chop_cnt_q;

    logic [10:0] prop_x;
    logic [9:0]  prop_y;
    logic [1:0]  pick_dir;
    logic        any_dir;
    logic        load_ok;

    // Pick the highest-priority pressed direction and its saturated target.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        prop_x   = x_out;
        prop_y   = y_out;
        pick_dir = direction_out;
        any_dir  = left_in | right_in | up_in | down_in;
        if (left_in) begin
            pick_dir = DIR_LEFT;
            prop_x   = (x_out < MIN_X_W + STEP_X) ? MIN_X_W : x_out - STEP_X;
        end else if (right_in) begin
            pick_dir = DIR_RIGHT;
            prop_x   = (x_out > MAX_X_W - STEP_X) ? MAX_X_W : x_out + STEP_X;
        end else if (up_in) begin
            pick_dir = DIR_UP;
            prop_y   = (y_out < MIN_Y_W + STEP_Y) ? MIN_Y_W : y_out - STEP_Y;
        end else if (down_in) begin
            pick_dir = DIR_DOWN;
            prop_y   = (y_out > MAX_Y_W - STEP_Y) ? MAX_Y_W : y_out + STEP_Y;
        end
    end

    assign load_ok = load_state_in && (new_state_in <= ST_MAX_CODE);

    // Frame sequencer: chop timing, move proposal, query completion, state loads.
    always_ff @(posedge pixel_clk_in) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
        if (!rst_n_in) begin
            fsm_q                 <= IDLE;
            chop_cnt_q            <= '0;
            x_out                 <= START_X_W;
            y_out                 <= START_Y_W;
            direction_out         <= DIR_DOWN;
            state_out             <= ST_NOTHING;
            chop_done_out         <= 1'b0;
            query.query_valid_out <= 1'b0;
            query.query_x_out     <= START_X_W;
            query.query_y_out     <= START_Y_W;
        end else begin
            // NOTE: non-blocking assignments; a later assignment in this block wins, which gives loads priority.
            chop_done_out <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (frame_tick_in) begin
                        if (state_out == ST_CHOPPING) begin
                            if (!chop_in) begin
                                state_out  <= ST_NOTHING;
                                chop_cnt_q <= '0;
                            end else if (chop_cnt_q == CHOP_LAST) begin
                                state_out     <= ST_NOTHING;
                                chop_cnt_q    <= '0;
                                chop_done_out <= 1'b1;
                            end else begin
                                chop_cnt_q <= chop_cnt_q + 1'b1;
                            end
                        end else if (state_out == ST_NOTHING && chop_in) begin
                            state_out  <= ST_CHOPPING;
                            chop_cnt_q <= '0;
                        end else if (any_dir) begin
                            direction_out <= pick_dir;
                            // A move pinned against the edge proposes nothing.
                            if (prop_x != x_out || prop_y != y_out) begin
                                query.query_x_out     <= prop_x;
                                query.query_y_out     <= prop_y;
                                query.query_valid_out <= 1'b1;
                                fsm_q                 <= QUERY;
                            end
                        end
                    end
                end
                QUERY: begin
                    // Frame ticks are dropped while waiting on the map.
                    if (query.query_ready_in) begin
                        query.query_valid_out <= 1'b0;
                        if (!query.blocked_in) begin
                            x_out <= query.query_x_out;
                            y_out <= query.query_y_out;
                        end
                        fsm_q <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase

            // A valid load overrides any tick-driven state change and aborts a chop.
            if (load_ok) begin
                state_out     <= new_state_in;
                chop_cnt_q    <= '0;
                chop_done_out <= 1'b0;
            end
        end
    end

endmodule
